sprite_layer_mixer: RTL
=======================

// Module: sprite_layer_mixer
// PURPOSE
//   Parametrised N-layer pixel compositor between sprite generators and the VGA pins.
//   Gates each layer with its enable, picks the lowest-index drawing layer, and expands colour to 4 bits/channel.
//   Delays hsync/vsync to stay aligned with the colour path.
//   Accumulates per-layer overlap (collision) flags over a frame and publishes them once per frame.
// PARAMETERS
//   LAYERS          16   number of sprite layers; layer 0 has highest priority (2..32)
//   CH_BITS         1    colour bits per channel per layer (1, 2 or 4)
//   SYNC_ACTIVE_LOW 1    1: hsync/vsync are active-low; sets the idle level and vsync edge detection
//   FRAME_W         16   width of frame_count
//   BG_RGB          0    3*CH_BITS background colour used when no layer draws
// PORTS
//   clk25        in   1             pixel clock, 25 MHz
//   rst          in   1             asynchronous reset, active-high
//   layer_valid  in   LAYERS        layer i's sprite pixel is opaque at the current x,y
//   layer_enable in   LAYERS        layer i is alive/active; 0 hides it and excludes it from collisions
//   layer_rgb    in   3*CH_BITS*LAYERS  packed; layer i at [3*CH_BITS*i +: 3*CH_BITS], order {R,G,B}
//   video_on_in  in   1             visible-area flag from the VGA controller
//   hsync_in     in   1             from the VGA controller
//   vsync_in     in   1             from the VGA controller
//   vga_r/g/b    out  4 each        composited colour
//   hsync_out    out  1             hsync_in delayed by 2 cycles
//   vsync_out    out  1             vsync_in delayed by 2 cycles
//   hit_mask     out  LAYERS        bit i = layer i overlapped another layer during the previous frame
//   frame_tick   out  1             1-cycle pulse when hit_mask updates
//   frame_count  out  FRAME_W       number of frames completed since reset
// BEHAVIOUR
//   Reset (async): vga_* = 0, hsync_out/vsync_out = idle level (1 if SYNC_ACTIVE_LOW, else 0),
//     hit_mask = 0, frame_tick = 0, frame_count = 0, accumulator = 0, all pipeline registers = 0.
//   Stage 1 (registered): g[i] = layer_valid[i] & layer_enable[i] & video_on_in.
//     Register g, layer_rgb, video_on_in, hsync_in and vsync_in.
//   Stage 2 (registered): winner = lowest i with g[i]=1.
//     Colour = layer_rgb[winner]; if no g[i] is set, colour = BG_RGB; if the stage-1 video_on is 0, colour = 0.
//   Colour expansion: each channel out = {(4/CH_BITS){ch}}, e.g. CH_BITS=1: bit b -> 4'bbbbb.
//   Latency: exactly 2 clk25 cycles from inputs to vga_*, hsync_out and vsync_out; no bubbles.
//   Collision: multi = (popcount(g) >= 2) in stage 1. Every cycle, acc |= g & {LAYERS{multi}}.
//   Frame boundary = start of the vsync pulse on vsync_in (falling edge if SYNC_ACTIVE_LOW, else rising edge),
//     detected against the stage-1 vsync register. In that cycle:
//     hit_mask <= acc | (that cycle's contribution); acc <= 0; frame_tick <= 1;
//     frame_count <= frame_count + 1, wrapping from 2^FRAME_W-1 to 0.
//   frame_tick is 0 in every other cycle. hit_mask holds its value between boundaries.
//   Frame state is two-valued: ACCUMULATE (all cycles) / PUBLISH (boundary cycle); no other states.
//   A collision occurring in the boundary cycle itself is included in the published mask, not the next one.
//   A layer with enable=0 never sets its hit bit, even if layer_valid=1.
//   Reset mid-frame: the first published mask after reset covers only the partial frame; this is legal.
//   vsync held constant (no controller running): no frame_tick, hit_mask stays 0.
// CONFIGURATION
//   MIXER_HIT_FLASH_EN defined:
//     A winning layer whose hit_mask bit is 1 outputs white (all channels 4'hF) instead of its layer_rgb.
//     This lasts for the whole frame following publication; the video_on=0 blanking rule still applies.
//   MIXER_HIT_FLASH_EN undefined: the colour is always layer_rgb[winner]; hit_mask affects only the port.
// TESTING
//   1 Reset: rst=1 mid-stream -> all outputs at reset values immediately; hsync_out=vsync_out=1.
//   2 Priority: g on layers 3 and 5, rgb3=3'b100, rgb5=3'b010, video_on=1
//       -> 2 cycles later vga_r=F, vga_g=0, vga_b=0.
//   3 Latency/blank: video_on_in=0 with layer 0 valid -> vga_* = 0.
//       A hsync_in toggle appears on hsync_out exactly 2 cycles later.
//   4 Collision: in one frame, layers 0 and 7 overlap for 1 pixel, layer 2 never overlaps
//       -> at the next vsync fall: frame_tick=1 for 1 cycle, hit_mask=0x0081, frame_count increments by 1.
//       The following frame with no overlap publishes 0x0000.
//   5 Edge cases: overlap in the boundary cycle itself -> included in the published mask.
//       frame_count at 0xFFFF -> wraps to 0x0000.
//       Overlap with layer_enable[7]=0 -> bit 7 stays clear.
//   6 MIXER_HIT_FLASH_EN: after hit_mask=0x0001, layer 0 winning pixels output F,F,F for one frame.
//       Without the macro they output rgb0.

Source files
------------

// File: rtl/sprite_layer_mixer.sv
// sprite_layer_mixer: N-layer sprite compositor in front of the VGA pins.
// Two-stage pipeline: stage 1 gates layers and registers the inputs, stage 2
// picks the lowest-index drawing layer and expands colour to 4 bits/channel.
// Syncs travel through the same two registers so they stay aligned with colour.
// Overlap flags are accumulated per frame and published at the start of vsync.
// Optional feature macro: MIXER_HIT_FLASH_EN (winning layers with a set hit
// bit are drawn white for the frame following publication).
module sprite_layer_mixer #(
    parameter int                   LAYERS          = 16,
    parameter int                   CH_BITS         = 1,
    parameter bit                   SYNC_ACTIVE_LOW = 1'b1,
    parameter int                   FRAME_W         = 16,
    parameter logic [3*CH_BITS-1:0] BG_RGB          = '0
) (
    input  logic                          clk25,
    input  logic                          rst,
    input  logic [LAYERS-1:0]             layer_valid,
    input  logic [LAYERS-1:0]             layer_enable,
    input  logic [3*CH_BITS*LAYERS-1:0]   layer_rgb,
    input  logic                          video_on_in,
    input  logic                          hsync_in,
    input  logic                          vsync_in,
    output logic [3:0]                    vga_r,
    output logic [3:0]                    vga_g,
    output logic [3:0]                    vga_b,
    output logic                          hsync_out,
    output logic                          vsync_out,
    output logic [LAYERS-1:0]             hit_mask,
    output logic                          frame_tick,
    output logic [FRAME_W-1:0]            frame_count
);

    localparam logic IDLE_LVL = SYNC_ACTIVE_LOW;

    typedef enum logic {
        ST_ACCUMULATE = 1'b0,
        ST_PUBLISH    = 1'b1
    } frame_state_t;

    // Replicate a CH_BITS channel value across 4 output bits.
    function automatic logic [3:0] expand(input logic [CH_BITS-1:0] c);
        logic [3:0] e;
        for (int b = 0; b < 4; b++) begin
            e[b] = c[b % CH_BITS];
        end
        return e;
    endfunction

    logic [LAYERS-1:0]           w_g;
    logic                        w_multi;
    logic [LAYERS-1:0]           w_contrib;
    logic                        w_boundary;

    logic [LAYERS-1:0]           r_g_p1;
    logic [3*CH_BITS*LAYERS-1:0] r_rgb_p1;
    logic                        r_von_p1;
    logic                        r_hs_p1;
    logic                        r_vs_p1;

    logic                        w_any;
    logic [3*CH_BITS-1:0]        w_sel_rgb;
    logic [3*CH_BITS-1:0]        w_pix;
    logic                        w_flash;
    logic [11:0]                 w_col;

    logic [LAYERS-1:0]           r_acc;
    frame_state_t                r_state;
    frame_state_t                w_state_nxt;

    // Stage-1 gating, overlap detection and frame-boundary detection.
    always_comb begin
        w_g        = layer_valid & layer_enable & {LAYERS{video_on_in}};
        w_multi    = |(w_g & (w_g - LAYERS'(1)));
        w_contrib  = w_multi ? w_g : '0;
        w_boundary = (vsync_in != IDLE_LVL) && (r_vs_p1 == IDLE_LVL);
    end

    // ---- stage 1 boundary: register gated layers, colours and syncs ----
    always_ff @(posedge clk25 or posedge rst) begin
        if (rst) begin
            r_g_p1   <= '0;
            r_rgb_p1 <= '0;
            r_von_p1 <= 1'b0;
            r_hs_p1  <= 1'b0;
            r_vs_p1  <= 1'b0;
        end else begin
            r_g_p1   <= w_g;
            r_rgb_p1 <= layer_rgb;
            r_von_p1 <= video_on_in;
            r_hs_p1  <= hsync_in;
            r_vs_p1  <= vsync_in;
        end
    end

    // Priority select: lowest-index gated layer wins.
    always_comb begin
        w_any     = 1'b0;
        w_sel_rgb = '0;
`ifdef MIXER_HIT_FLASH_EN
        w_flash   = 1'b0;
`endif
        for (int i = LAYERS - 1; i >= 0; i--) begin
            if (r_g_p1[i]) begin
                w_any     = 1'b1;
                w_sel_rgb = r_rgb_p1[3*CH_BITS*i +: 3*CH_BITS];
`ifdef MIXER_HIT_FLASH_EN
                w_flash   = hit_mask[i];
`endif
            end
        end
`ifndef MIXER_HIT_FLASH_EN
        w_flash = 1'b0;
`endif
    end

    // Colour choice, expansion, flash override and blanking.
    always_comb begin
        w_pix = w_any ? w_sel_rgb : BG_RGB;
        w_col = {expand(w_pix[3*CH_BITS-1 -: CH_BITS]),
                 expand(w_pix[2*CH_BITS-1 -: CH_BITS]),
                 expand(w_pix[CH_BITS-1:0])};
        if (w_any && w_flash) begin
            w_col = 12'hFFF;
        end
        if (!r_von_p1) begin
            w_col = 12'h000;
        end
    end

    // ---- stage 2 boundary: register composited colour and delayed syncs ----
    always_ff @(posedge clk25 or posedge rst) begin
        if (rst) begin
            vga_r     <= 4'h0;
            vga_g     <= 4'h0;
            vga_b     <= 4'h0;
            hsync_out <= IDLE_LVL;
            vsync_out <= IDLE_LVL;
        end else begin
            vga_r     <= w_col[11:8];
            vga_g     <= w_col[7:4];
            vga_b     <= w_col[3:0];
            hsync_out <= r_hs_p1;
            vsync_out <= r_vs_p1;
        end
    end

    // Frame state register: PUBLISH lasts exactly the cycle after a boundary.
    always_ff @(posedge clk25 or posedge rst) begin
        if (rst) begin
            r_state <= ST_ACCUMULATE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Frame next-state: publish whenever a vsync pulse starts.
    always_comb begin
        w_state_nxt = w_boundary ? ST_PUBLISH : ST_ACCUMULATE;
    end

    // Frame outputs: tick is high only while in PUBLISH.
    always_comb begin
        frame_tick = (r_state == ST_PUBLISH);
    end

    // Overlap accumulator, published mask and frame counter.
    always_ff @(posedge clk25 or posedge rst) begin
        if (rst) begin
            r_acc       <= '0;
            hit_mask    <= '0;
            frame_count <= '0;
        end else if (w_boundary) begin
            // The boundary cycle's own overlap belongs to the frame being closed.
            hit_mask    <= r_acc | w_contrib;
            r_acc       <= '0;
            frame_count <= frame_count + FRAME_W'(1);
        end else begin
            r_acc       <= r_acc | w_contrib;
        end
    end

endmodule
